// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: cache-side and bridge-side signals of the L1-to-AXI request sequencer
interface mem_req_arbiter_if;
  logic         ic_req_i;
  logic [31:0]  ic_addr_i;
  logic         ic_ack_o;
  logic         ic_rvalid_o;
  logic [127:0] ic_rdata_o;
  logic         dc_rreq_i;
  logic [31:0]  dc_raddr_i;
  logic         dc_rack_o;
  logic         dc_rvalid_o;
  logic [127:0] dc_rdata_o;
  logic         dc_wreq_i;
  logic [31:0]  dc_waddr_i;
  logic [127:0] dc_wdata_i;
  logic         dc_wack_o;
  logic         dc_bvalid_o;
  logic         br_inst_ren_o;
  logic [31:0]  br_inst_araddr_o;
  logic         br_data_ren_o;
  logic [31:0]  br_data_araddr_o;
  logic         br_data_wen_o;
  logic [31:0]  br_data_awaddr_o;
  logic [127:0] br_data_wdata_o;
  logic         br_inst_rvalid_i;
  logic [127:0] br_inst_rdata_i;
  logic         br_data_rvalid_i;
  logic [127:0] br_data_rdata_i;
  logic         br_bvalid_i;
  logic         br_rrdy_i;
  logic         br_wrdy_i;
  modport slave (
    input  ic_req_i, ic_addr_i, dc_rreq_i, dc_raddr_i, dc_wreq_i, dc_waddr_i, dc_wdata_i,
           br_inst_rvalid_i, br_inst_rdata_i, br_data_rvalid_i, br_data_rdata_i,
           br_bvalid_i, br_rrdy_i, br_wrdy_i,
    output ic_ack_o, ic_rvalid_o, ic_rdata_o, dc_rack_o, dc_rvalid_o, dc_rdata_o,
           dc_wack_o, dc_bvalid_o, br_inst_ren_o, br_inst_araddr_o, br_data_ren_o,
           br_data_araddr_o, br_data_wen_o, br_data_awaddr_o, br_data_wdata_o
  );
  modport master (
    output ic_req_i, ic_addr_i, dc_rreq_i, dc_raddr_i, dc_wreq_i, dc_waddr_i, dc_wdata_i,
           br_inst_rvalid_i, br_inst_rdata_i, br_data_rvalid_i, br_data_rdata_i,
           br_bvalid_i, br_rrdy_i, br_wrdy_i,
    input  ic_ack_o, ic_rvalid_o, ic_rdata_o, dc_rack_o, dc_rvalid_o, dc_rdata_o,
           dc_wack_o, dc_bvalid_o, br_inst_ren_o, br_inst_araddr_o, br_data_ren_o,
           br_data_araddr_o, br_data_wen_o, br_data_awaddr_o, br_data_wdata_o
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: arbitrates icache/dcache fills onto one bridge read channel and buffers dcache write-backs
module mem_req_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  mem_req_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT} w_state_t;
  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic          src_dc;
  logic [31:0]   raddr, waddr;
  logic [127:0]  wdata, ic_rdata, dc_rdata;
  logic [CW-1:0] starve;
  logic ic_ack, dc_rack, dc_wack, ic_rvalid, dc_rvalid, dc_bvalid;
  logic w_busy, w_take, hazard, dc_elig, grant_ic, grant_dc, r_done;
  assign w_busy = w_state != W_IDLE;
  assign w_take = w_state == W_IDLE && bus.dc_wreq_i && !dc_bvalid;
  // A write-back being captured this very cycle also blocks a fill of the same burst line
  assign hazard = (w_busy && bus.dc_raddr_i[31:5] == waddr[31:5]) ||
                  (w_take && bus.dc_raddr_i[31:5] == bus.dc_waddr_i[31:5]);
  assign dc_elig  = bus.dc_rreq_i && !hazard;
  assign grant_ic = r_state == R_IDLE && bus.ic_req_i && (!dc_elig || starve == CW'(STARVE_LIMIT));
  assign grant_dc = r_state == R_IDLE && dc_elig && !grant_ic;
  assign r_done   = r_state == R_WAIT && (src_dc ? bus.br_data_rvalid_i : bus.br_inst_rvalid_i);
  always_comb begin
    r_next = r_state;
    w_next = w_state;
    case (r_state)
      R_IDLE:  r_next = grant_ic || grant_dc ? R_ISSUE : R_IDLE;
      R_ISSUE: r_next = bus.br_rrdy_i ? R_WAIT : R_ISSUE;
      R_WAIT:  r_next = r_done ? R_IDLE : R_WAIT;
      default: r_next = R_IDLE;
    endcase
    case (w_state)
      W_IDLE:  w_next = w_take ? W_ISSUE : W_IDLE;
      W_ISSUE: w_next = bus.br_wrdy_i ? W_WAIT : W_ISSUE;
      W_WAIT:  w_next = bus.br_bvalid_i ? W_IDLE : W_WAIT;
      default: w_next = W_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_dc    <= 1'b0;
      raddr     <= '0;
      waddr     <= '0;
      wdata     <= '0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
      starve    <= '0;
      ic_ack    <= 1'b0;
      dc_rack   <= 1'b0;
      dc_wack   <= 1'b0;
      ic_rvalid <= 1'b0;
      dc_rvalid <= 1'b0;
      dc_bvalid <= 1'b0;
    end else begin
      ic_ack    <= grant_ic;
      dc_rack   <= grant_dc;
      dc_wack   <= w_take;
      ic_rvalid <= r_done && !src_dc;
      dc_rvalid <= r_done && src_dc;
      dc_bvalid <= w_state == W_WAIT && bus.br_bvalid_i;
      starve    <= !bus.ic_req_i || grant_ic ? '0 :
                   grant_dc && starve != CW'(STARVE_LIMIT) ? starve + 1'b1 : starve;
      if (grant_ic || grant_dc) begin
        src_dc <= grant_dc;
        raddr  <= grant_dc ? bus.dc_raddr_i : bus.ic_addr_i;
      end
      if (r_done && !src_dc) ic_rdata <= bus.br_inst_rdata_i;
      if (r_done && src_dc) dc_rdata <= bus.br_data_rdata_i;
      if (w_take) begin
        waddr <= bus.dc_waddr_i;
        wdata <= bus.dc_wdata_i;
      end
    end
  end
  assign bus.ic_ack_o         = ic_ack;
  assign bus.dc_rack_o        = dc_rack;
  assign bus.dc_wack_o        = dc_wack;
  assign bus.ic_rvalid_o      = ic_rvalid;
  assign bus.dc_rvalid_o      = dc_rvalid;
  assign bus.dc_bvalid_o      = dc_bvalid;
  assign bus.ic_rdata_o       = ic_rdata;
  assign bus.dc_rdata_o       = dc_rdata;
  assign bus.br_inst_ren_o    = r_state == R_ISSUE && !src_dc;
  assign bus.br_data_ren_o    = r_state == R_ISSUE && src_dc;
  assign bus.br_inst_araddr_o = r_state != R_IDLE && !src_dc ? raddr : '0;
  assign bus.br_data_araddr_o = r_state != R_IDLE && src_dc ? raddr : '0;
  assign bus.br_data_wen_o    = w_state == W_ISSUE;
  assign bus.br_data_awaddr_o = w_busy ? waddr : '0;
  assign bus.br_data_wdata_o  = w_busy ? wdata : '0;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed stimulus with cache/bridge agents and a queue-based scoreboard monitor
module tb_mem_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_req_arbiter_if bus();
  mem_req_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  int rlat = 8;
  int wlat = 4;
  logic [31:0]  ic_q[$], dc_q[$];
  logic [159:0] wr_q[$];
  logic         exp_ack[$];
  logic [32:0]  exp_rd[$];
  logic [127:0] exp_icl[$], exp_dcl[$];
  logic [159:0] exp_wr[$];
  logic [31:0]  exp_wack[$];
  logic         exp_b[$];
  logic prev_irv, prev_drv, prev_bv, m_dc, rb_dc;
  logic [31:0]  m_addr, rb_addr;
  logic [127:0] m_line;
  logic [159:0] m_wr;
  logic [488:0] all_o;
  logic [12:0]  ord;
  assign all_o = {bus.ic_ack_o, bus.ic_rvalid_o, bus.ic_rdata_o, bus.dc_rack_o, bus.dc_rvalid_o,
                  bus.dc_rdata_o, bus.dc_wack_o, bus.dc_bvalid_o, bus.br_inst_ren_o,
                  bus.br_inst_araddr_o, bus.br_data_ren_o, bus.br_data_araddr_o,
                  bus.br_data_wen_o, bus.br_data_awaddr_o, bus.br_data_wdata_o};
  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a, ~a, 64'hDEADBEEF_000000A5};
  endfunction
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_read(input logic dc, input logic [31:0] a, input logic [127:0] line);
    if (dc) dc_q.push_back(a); else ic_q.push_back(a);
    exp_ack.push_back(dc);
    exp_rd.push_back({dc, a});
    if (dc) exp_dcl.push_back(line); else exp_icl.push_back(line);
  endtask
  task automatic do_write(input logic [31:0] a, input logic [127:0] d);
    wr_q.push_back({a, d});
    exp_wack.push_back(a);
    exp_wr.push_back({a, d});
    exp_b.push_back(1'b1);
  endtask
  function automatic int pending();
    return ic_q.size() + dc_q.size() + wr_q.size() + exp_ack.size() + exp_rd.size() +
           exp_icl.size() + exp_dcl.size() + exp_wr.size() + exp_wack.size() + exp_b.size();
  endfunction
  task automatic sync();
    @(posedge clk);
    #2;
  endtask
  task automatic drain();
    int n = 0;
    while (pending() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain timeout", 160'(n >= 400), 160'(0));
    repeat (3) @(negedge clk);
  endtask
  task automatic wait_for(input int which, input int budget);
    int n = 0;
    logic s;
    s = which == 0 ? bus.ic_ack_o : which == 1 ? bus.dc_rack_o : bus.dc_bvalid_o;
    while (!s && n < budget) begin
      @(negedge clk);
      n++;
      s = which == 0 ? bus.ic_ack_o : which == 1 ? bus.dc_rack_o : bus.dc_bvalid_o;
    end
    chk("wait timeout", 160'(n >= budget), 160'(0));
  endtask
  // Requester agents: hold the level request until the ack pulse is seen
  initial begin
    bus.ic_req_i = 1'b0;
    bus.ic_addr_i = '0;
    forever begin
      @(negedge clk);
      if (bus.ic_req_i && bus.ic_ack_o) void'(ic_q.pop_front());
      bus.ic_req_i = ic_q.size() != 0;
      bus.ic_addr_i = ic_q.size() != 0 ? ic_q[0] : 32'h0;
    end
  end
  initial begin
    bus.dc_rreq_i = 1'b0;
    bus.dc_raddr_i = '0;
    forever begin
      @(negedge clk);
      if (bus.dc_rreq_i && bus.dc_rack_o) void'(dc_q.pop_front());
      bus.dc_rreq_i = dc_q.size() != 0;
      bus.dc_raddr_i = dc_q.size() != 0 ? dc_q[0] : 32'h0;
    end
  end
  initial begin
    bus.dc_wreq_i = 1'b0;
    bus.dc_waddr_i = '0;
    bus.dc_wdata_i = '0;
    forever begin
      @(negedge clk);
      if (bus.dc_wreq_i && bus.dc_wack_o) void'(wr_q.pop_front());
      bus.dc_wreq_i = wr_q.size() != 0;
      {bus.dc_waddr_i, bus.dc_wdata_i} = wr_q.size() != 0 ? wr_q[0] : 160'h0;
    end
  end
  // Bridge read model: returns line_of(addr) rlat cycles after the ren/rrdy handshake
  initial begin
    bus.br_inst_rvalid_i = 1'b0;
    bus.br_inst_rdata_i = '0;
    bus.br_data_rvalid_i = 1'b0;
    bus.br_data_rdata_i = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst && bus.br_rrdy_i && (bus.br_inst_ren_o || bus.br_data_ren_o)) begin
        rb_dc = bus.br_data_ren_o;
        rb_addr = rb_dc ? bus.br_data_araddr_o : bus.br_inst_araddr_o;
        repeat (rlat) @(negedge clk);
        if (rb_dc) begin
          bus.br_data_rvalid_i = 1'b1;
          bus.br_data_rdata_i = line_of(rb_addr);
        end else begin
          bus.br_inst_rvalid_i = 1'b1;
          bus.br_inst_rdata_i = line_of(rb_addr);
        end
        @(negedge clk);
        bus.br_inst_rvalid_i = 1'b0;
        bus.br_data_rvalid_i = 1'b0;
      end
    end
  end
  initial begin
    bus.br_bvalid_i = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst && bus.br_wrdy_i && bus.br_data_wen_o) begin
        repeat (wlat) @(negedge clk);
        bus.br_bvalid_i = 1'b1;
        @(negedge clk);
        bus.br_bvalid_i = 1'b0;
      end
    end
  end
  // Scoreboard monitor: pops an expectation whenever the DUT presents an event
  initial begin
    prev_irv = 1'b0;
    prev_drv = 1'b0;
    prev_bv = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        if (bus.ic_ack_o || bus.dc_rack_o) begin
          if (exp_ack.size() == 0) chk("unexpected read ack", {bus.ic_ack_o, bus.dc_rack_o}, 160'(0));
          else begin
            m_dc = exp_ack.pop_front();
            chk("read grant", {bus.ic_ack_o, bus.dc_rack_o}, {!m_dc, m_dc});
          end
        end
        if (bus.br_rrdy_i && (bus.br_inst_ren_o || bus.br_data_ren_o)) begin
          m_addr = bus.br_data_ren_o ? bus.br_data_araddr_o : bus.br_inst_araddr_o;
          if (exp_rd.size() == 0) chk("unexpected read issue", {bus.br_inst_ren_o, bus.br_data_ren_o}, 160'(0));
          else begin
            {m_dc, m_addr} = exp_rd.pop_front();
            chk("read issue", {bus.br_inst_ren_o, bus.br_data_ren_o,
                bus.br_data_ren_o ? bus.br_data_araddr_o : bus.br_inst_araddr_o}, {!m_dc, m_dc, m_addr});
          end
        end
        if (bus.ic_rvalid_o) begin
          chk("ic rvalid follows bridge", 160'(prev_irv), 160'(1));
          if (exp_icl.size() == 0) chk("unexpected ic rvalid", 160'(bus.ic_rvalid_o), 160'(0));
          else begin
            m_line = exp_icl.pop_front();
            chk("ic line", bus.ic_rdata_o, m_line);
          end
        end
        if (bus.dc_rvalid_o) begin
          chk("dc rvalid follows bridge", 160'(prev_drv), 160'(1));
          if (exp_dcl.size() == 0) chk("unexpected dc rvalid", 160'(bus.dc_rvalid_o), 160'(0));
          else begin
            m_line = exp_dcl.pop_front();
            chk("dc line", bus.dc_rdata_o, m_line);
          end
        end
        if (bus.dc_wack_o) begin
          if (exp_wack.size() == 0) chk("unexpected write ack", 160'(bus.dc_wack_o), 160'(0));
          else begin
            m_addr = exp_wack.pop_front();
            chk("write capture", bus.br_data_awaddr_o, m_addr);
          end
        end
        if (bus.br_data_wen_o && bus.br_wrdy_i) begin
          if (exp_wr.size() == 0) chk("unexpected write issue", 160'(bus.br_data_wen_o), 160'(0));
          else begin
            m_wr = exp_wr.pop_front();
            chk("write issue", {bus.br_data_awaddr_o, bus.br_data_wdata_o}, m_wr);
          end
        end
        if (bus.dc_bvalid_o) begin
          chk("bvalid follows bridge", 160'(prev_bv), 160'(1));
          if (exp_b.size() == 0) chk("unexpected bvalid", 160'(bus.dc_bvalid_o), 160'(0));
          else begin
            void'(exp_b.pop_front());
            chk("write idle after complete", {bus.br_data_wen_o, bus.br_data_awaddr_o}, 160'(0));
          end
        end
      end
      prev_irv = bus.br_inst_rvalid_i;
      prev_drv = bus.br_data_rvalid_i;
      prev_bv = bus.br_bvalid_i;
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int n;
    bus.br_rrdy_i = 1'b1;
    bus.br_wrdy_i = 1'b1;
    #3;
    chk("reset outputs", 160'($countones(all_o)), 160'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // Single icache fill with slow bridge
    sync();
    rlat = 8;
    do_read(1'b0, 32'h1C00_0040, 128'h1C000040_E3FFFFBF_DEADBEEF_000000A5);
    wait_for(0, 20);
    n = 0;
    while (!bus.ic_rvalid_o && n < 40) begin
      chk("ic addr stable", bus.br_inst_araddr_o, 32'h1C00_0040);
      chk("dc side silent", {bus.dc_rack_o, bus.dc_rvalid_o, bus.br_data_ren_o, bus.br_data_wen_o,
          bus.br_data_araddr_o}, 160'(0));
      @(negedge clk);
      n++;
    end
    chk("ic rvalid timeout", 160'(n >= 40), 160'(0));
    @(negedge clk);
    chk("ic pulses one cycle", {bus.ic_rvalid_o, bus.ic_ack_o}, 160'(0));
    drain();
    // Both caches hammering: DC x4 then forced IC
    sync();
    rlat = 2;
    ord = 13'b1111011110110;
    for (int k = 0, di = 0, ii = 0; k < 13; k++) begin
      if (ord[12-k]) begin
        do_read(1'b1, 32'h0000_8000 + 32'(di) * 32'h40, line_of(32'h0000_8000 + 32'(di) * 32'h40));
        di++;
      end else begin
        do_read(1'b0, 32'h0001_0000 + 32'(ii) * 32'h40, line_of(32'h0001_0000 + 32'(ii) * 32'h40));
        ii++;
      end
    end
    drain();
    // Write-back and same-line fill raised together: fill waits for completion
    sync();
    wlat = 6;
    do_write(32'h0000_1000, 128'h11112222_33334444_55556666_77778888);
    do_read(1'b1, 32'h0000_1010, line_of(32'h0000_1010));
    n = 0;
    while (!bus.dc_bvalid_o && n < 60) begin
      @(negedge clk);
      n++;
      chk("hazard blocks read", {bus.br_data_ren_o, bus.dc_rack_o}, 160'(0));
    end
    chk("bvalid timeout", 160'(n >= 60), 160'(0));
    @(negedge clk);
    chk("read after bvalid", {bus.br_data_ren_o, bus.br_data_araddr_o}, {1'b1, 32'h0000_1010});
    drain();
    // Different lines proceed concurrently
    sync();
    do_write(32'h0000_3000, 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0);
    do_read(1'b1, 32'h0000_2000, line_of(32'h0000_2000));
    wait_for(1, 20);
    chk("read and write concurrent", {bus.br_data_ren_o, bus.br_data_wen_o}, 160'(2'b11));
    drain();
    // Bridge read channel busy: hold ren and address
    sync();
    bus.br_rrdy_i = 1'b0;
    do_read(1'b0, 32'h4000_0080, line_of(32'h4000_0080));
    wait_for(0, 20);
    for (int k = 0; k < 5; k++) begin
      chk("ren held while not ready", {bus.br_inst_ren_o, bus.br_inst_araddr_o}, {1'b1, 32'h4000_0080});
      @(negedge clk);
    end
    bus.br_rrdy_i = 1'b1;
    @(negedge clk);
    chk("ren drops after ready", {bus.br_inst_ren_o, bus.br_inst_araddr_o}, {1'b0, 32'h4000_0080});
    drain();
    // Reset while read and write are both waiting on the bridge
    sync();
    rlat = 10;
    wlat = 10;
    do_read(1'b0, 32'h0000_5000, line_of(32'h0000_5000));
    do_write(32'h0000_6000, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);
    wait_for(0, 20);
    repeat (3) @(negedge clk);
    chk("both waiting", {bus.br_inst_ren_o, bus.br_inst_araddr_o, bus.br_data_wen_o, bus.br_data_awaddr_o},
        {1'b0, 32'h0000_5000, 1'b0, 32'h0000_6000});
    #2;
    rst = 1'b0;
    #1;
    chk("async reset outputs", 160'($countones(all_o)), 160'(0));
    exp_icl.delete();
    exp_b.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("no completion after reset", {bus.ic_rvalid_o, bus.dc_bvalid_o, bus.ic_rdata_o}, 160'(0));
    sync();
    rlat = 2;
    wlat = 4;
    do_read(1'b0, 32'h0000_7000, line_of(32'h0000_7000));
    do_write(32'h0000_9000, 128'h01020304_05060708_090A0B0C_0D0E0F10);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Sequencer between the L1 caches and the cache-to-AXI bridge. Captures icache line-fill, dcache line-fill and dcache write-back requests, and arbitrates the bridge's single read channel between the two caches with bounded icache starvation. Holds each transaction's address and data stable until the bridge completes it. Blocks any dcache fill whose line matches an outstanding write-back until that write-back is acknowledged.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive dcache read grants while icache waits before icache is forced.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ic_req_i  in  1  icache fill request, level, held until ic_ack_o
- ic_addr_i  in  32  icache fill address
- ic_ack_o  out  1  one-cycle pulse: ic request captured
- ic_rvalid_o  out  1  one-cycle pulse: ic_rdata_o valid
- ic_rdata_o  out  128  icache fill line
- dc_rreq_i / dc_raddr_i  in  1 / 32  dcache fill request / address, same rules as ic
- dc_rack_o / dc_rvalid_o  out  1 / 1  capture pulse / data-valid pulse
- dc_rdata_o  out  128  dcache fill line
- dc_wreq_i  in  1  write-back request, level, held until dc_wack_o
- dc_waddr_i / dc_wdata_i  in  32 / 128  write-back address / line
- dc_wack_o  out  1  pulse: write-back captured into buffer
- dc_bvalid_o  out  1  pulse: write-back completed
- br_inst_ren_o / br_inst_araddr_o  out  1 / 32  bridge icache read port
- br_data_ren_o / br_data_araddr_o  out  1 / 32  bridge dcache read port
- br_data_wen_o / br_data_awaddr_o / br_data_wdata_o  out  1 / 32 / 128  bridge write port
- br_inst_rvalid_i / br_inst_rdata_i  in  1 / 128  bridge icache return
- br_data_rvalid_i / br_data_rdata_i  in  1 / 128  bridge dcache return
- br_bvalid_i  in  1  bridge write complete
- br_rrdy_i / br_wrdy_i  in  1 / 1  bridge read / write channel free

## Operation
- Read FSM: R_IDLE -> R_ISSUE -> R_WAIT -> R_IDLE. Source tag SRC (IC/DC) and address captured on R_IDLE exit.
- Grant in R_IDLE, eligible requests only: DC wins by default; IC wins if only IC eligible or starve count == STARVE_LIMIT. DC is ineligible while hazard set.
- Hazard: write buffer valid and dc_raddr_i[31:5] == buffered waddr[31:5] (bridge burst granularity).
- Starve count: +1 per DC grant while ic_req_i high; cleared on IC grant or when ic_req_i low; saturates at STARVE_LIMIT.
- R_ISSUE: drive ren of SRC port, address from capture register; on ren & br_rrdy_i -> R_WAIT. R_WAIT: ren low, address held stable; on SRC rvalid -> register data, pulse rvalid_o next cycle, -> R_IDLE.
- Write FSM: W_IDLE -> W_ISSUE -> W_WAIT -> W_IDLE with one-entry buffer (valid, addr, data). W_IDLE & dc_wreq_i captures buffer. W_ISSUE drives br_data_wen_o until br_wrdy_i sampled high with it -> W_WAIT. W_WAIT on br_bvalid_i -> pulse dc_bvalid_o, clear valid -> W_IDLE.
- awaddr/wdata held from buffer throughout W_ISSUE and W_WAIT. Read and write may be outstanding concurrently when no hazard.
- Non-selected bridge enables and all addresses driven 0 when idle.

## Timing
- Reset: all FSMs IDLE, buffer invalid, starve count 0, every output 0 including rdata registers. Mid-transaction reset drops the transaction; no completion pulse.
- ack pulses are registered: high the cycle after capture, exactly one cycle. Requester sees ack while req still high; no re-capture because FSM is no longer IDLE.
- Min read latency: capture edge T, ren high T+1; if br_rrdy_i then R_WAIT at T+2. rvalid_o is one cycle after bridge rvalid.
- Write: dc_bvalid_o one cycle after br_bvalid_i. New write-back accepted no earlier than the cycle after dc_bvalid_o.
- Same-cycle dc_wreq_i and matching dc_rreq_i: write captured, read stalls until dc_bvalid_o.
- Same-cycle ic and dc requests with count < limit: DC acked, IC waits.
- br_rrdy_i low in R_ISSUE: hold ren and address indefinitely.

## Test plan
- Reset, single IC fill 0x1C000040, bridge returns line 0x...A5 after 8 cycles -> ic_ack_o once, br_inst_araddr_o = 0x1C000040 stable, ic_rvalid_o one cycle later with data, dc outputs silent.
- IC and DC held continuously, STARVE_LIMIT=4 -> grant order DC,DC,DC,DC,IC,DC,...
- Write-back 0x00001000 pending, DC fill 0x00001010 -> no br_data_ren_o until cycle after dc_bvalid_o. DC fill 0x00002000 issues concurrently with the write.
- br_rrdy_i held low 5 cycles in R_ISSUE -> ren and address steady, transition on first rrdy.
- Assert rst low during R_WAIT and W_WAIT -> all outputs 0 asynchronously, no rvalid/bvalid after release, next request served normally.
